serializador_param: RTL
=======================

# serializador_param

- Parametrised parallel-to-serial converter: successor to the fixed 8-bit serializer in the transmit path.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- After reset, sends a programmable number of idle words before it accepts data; from then on it inserts the idle word whenever no data is offered.
- Sits between the lane byte-striping logic and the physical serial output, running on the bit-rate clock.

## Interface
- Parameters:
  - WIDTH, 8: data word width in bits (≥2).
  - IDLE_WORD, 'hBC: word sent when there is no data (WIDTH bits).
  - SYNC_WORDS, 4: idle words sent after reset before `active` asserts (≥1).
  - LSB_FIRST, 0: 0 = MSB first on the line; 1 = LSB first.
- Ports (one clock; reset is asynchronous and active-high):
  - clk_32f, input, 1: bit-rate clock; all state updates on the rising edge.
  - reset, input, 1: asynchronous, active-high reset.
  - data_in, input, WIDTH: word to transmit.
  - valid_in, input, 1: data_in holds a valid word.
  - ready_out, output, 1: block will load data_in at the next edge.
  - data_out, output, 1: serial line.
  - word_start, output, 1: high while data_out carries the first bit of a frame.
  - active, output, 1: sync sequence complete; data is accepted.

## Operation
- Frame length F = WIDTH; F = WIDTH+1 when parity is compiled in (see Configuration).
- State:
  - shift register sh (F bits)
  - bit counter bc, 0..F-1
  - idle counter ic, 0..SYNC_WORDS
  - FSM: SYNC, ACTIVE
- Reset (asynchronous, immediate): sh=0, bc=F-1, ic=0, state SYNC. Outputs: data_out=0, ready_out=0, word_start=0, active=0.
- Load edge: any edge with bc==F-1.
  - sh is loaded with the next frame and bc goes to 0.
  - Otherwise sh shifts toward the output end and bc increments.
- Next frame:
  - data_in, if state is ACTIVE and valid_in is high (a handshake);
  - otherwise IDLE_WORD.
- ready_out = active AND bc==F-1. It is combinational from registers and does not depend on valid_in.
- Handshake: a transfer happens on an edge where valid_in and ready_out are both high.
  - The producer must hold data_in and valid_in stable until that transfer.
  - Nothing is dropped or duplicated.
- data_out = output-end bit of sh (registered). LSB_FIRST selects the bit order on the line.
- word_start = registered (bc==0 after the edge): high for exactly one cycle per frame, aligned with the frame's first bit.
- SYNC state:
  - Each load edge increments ic.
  - The load edge at which ic==SYNC_WORDS still loads IDLE_WORD, moves the FSM to ACTIVE and sets active=1.
- ACTIVE state: stays until reset. Idle insertion is the only fill mechanism; there is no underflow error.
- Reset mid-frame: the partial frame is aborted, the line drops to 0 immediately, and the full sync sequence repeats.

## Timing
- Edge numbering: edge 1 is the first rising edge after reset deasserts.
- Load edges: edges 1, 1+F, 1+2F, …
- Bit k of a frame is on data_out during cycle k after its load edge (k = 0..F-1).
- Latency: a word accepted at edge E has its first bit valid after E and its last bit after E+F-1.
- Throughput: one word per F cycles. Back-to-back words leave no gap bits.
- active rises at load edge SYNC_WORDS+1. ready_out first goes high in the cycle before load edge SYNC_WORDS+2.
  - Example, WIDTH=8, SYNC_WORDS=4: active rises at edge 33; the first accept is at edge 41.
- valid_in changes between load edges are ignored. Only its value at a load edge matters.

## Configuration
- PARITY_EN defined:
  - An even-parity bit (XOR of the WIDTH data bits) is appended as the last bit of every frame, idle frames included.
  - F = WIDTH+1, and the ready_out period becomes WIDTH+1.
- PARITY_EN undefined: F = WIDTH, no parity bit, and no extra logic.

## Test plan
- Reset release, valid_in=0, WIDTH=8, MSB first: data_out repeats 1,0,1,1,1,1,0,0 (0xBC) from edge 1; word_start high at edges 1, 9, 17…; active rises at edge 33.
- Hold valid_in=1 with data_in=0xA5 from edge 0: no transfer before edge 41; 0xA5 appears as 1,0,1,0,0,1,0,1 after edge 41; ready_out is high only in the cycles before edges 41, 49, ….
- Three back-to-back words 0x01, 0xFF, 0x3C, then valid_in=0: the line shows exactly those 24 bits with no gap, followed by 0xBC idles.
- LSB_FIRST=1, data_in=0x80: the line shows 0,0,0,0,0,0,0,1.
- Assert reset at bit 3 of a data frame: data_out=0 and active=0 immediately; after release the full 4-idle sync repeats and the interrupted word is not resent.
- PARITY_EN defined, data_in=0x07: 9-bit frame 0,0,0,0,0,1,1,1,1; the idle frame 0xBC carries parity 1; the ready_out period is 9 cycles.

Source files
------------

// File: rtl/serializador_param.sv
// Parallel-to-serial transmitter: WIDTH-bit words over valid/ready, one bit per clk_32f,
// idle-word fill and post-reset sync preamble. Define PARITY_EN to append an even-parity bit.
module serializador_param #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD  = 'hBC,
    parameter int               SYNC_WORDS = 4,
    parameter int               LSB_FIRST  = 0
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             active
);

`ifdef PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam int BC_W = $clog2(F);
    localparam int IC_W = $clog2(SYNC_WORDS + 1);

    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(F - 1);
    localparam logic [IC_W-1:0] IC_LAST  = IC_W'(SYNC_WORDS);
    localparam logic [0:0]      ST_SYNC   = 1'b0;
    localparam logic [0:0]      ST_ACTIVE = 1'b1;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic [F-1:0]     r_sh;
    logic [BC_W-1:0]  r_bc;
    logic [IC_W-1:0]  r_ic;
    logic [0:0]       r_state;
    logic             r_word_start;

    logic             w_load;
    logic             w_take;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_ordered;
    logic [F-1:0]     w_frame;

    assign w_load    = (r_bc == BC_LAST);
    assign w_take    = w_load && (r_state == ST_ACTIVE) && valid_in;
    assign w_word    = w_take ? data_in : IDLE_WORD;
    // The frame is held with its first line bit at the top, so the line always shifts left.
    assign w_ordered = (LSB_FIRST != 0) ? bit_reverse(w_word) : w_word;

`ifdef PARITY_EN
    assign w_frame = {w_ordered, ^w_word};
`else
    assign w_frame = w_ordered;
`endif

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_sh         <= '0;
            r_bc         <= BC_LAST;
            r_word_start <= 1'b0;
        end else if (w_load) begin
            r_sh         <= w_frame;
            r_bc         <= '0;
            r_word_start <= 1'b1;
        end else begin
            r_sh         <= {r_sh[F-2:0], 1'b0};
            r_bc         <= r_bc + 1'b1;
            r_word_start <= 1'b0;
        end
    end

    // Sync preamble: the load edge that finds ic==SYNC_WORDS still sends idle, then goes active.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_ic    <= '0;
            r_state <= ST_SYNC;
        end else if (w_load && (r_state == ST_SYNC)) begin
            if (r_ic == IC_LAST) begin
                r_state <= ST_ACTIVE;
            end else begin
                r_ic <= r_ic + 1'b1;
            end
        end
    end

    assign data_out   = r_sh[F-1];
    assign word_start = r_word_start;
    assign active     = (r_state == ST_ACTIVE);
    assign ready_out  = active && w_load;

endmodule
